axi4_lite_regfile_slave: RTL and testbench

//  AXI4-Lite responder: terminates the master's AW/W/B/AR/R channels in a bank of NUM_REGS memory-mapped registers.
//  Reg 0 is a read-only ID; regs 1..NUM_REGS-1 are R/W with byte strobes. Sits opposite the AXI4-Lite master in the top wrapper.
//  Out-of-range, misaligned and read-only-target accesses answer SLVERR.

---
 rtl/axi4_lite_pkg.sv | 12 +
 rtl/axi4_lite_reg_bank.sv | 53 +++++
 rtl/axi4_lite_regfile_slave.sv | 149 ++++++++++++++
 tb/tb_axi4_lite_regfile_slave.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by both the master and the slave side.
//   resp_t      : 2-bit B/R channel response code
//   RESP_OKAY   : normal access completed
//   RESP_SLVERR : access rejected by the slave (bad address or read-only target)
package axi4_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage for the AXI4-Lite slave.
//   clk, rst  : clock, synchronous active-high reset (clears regs 1..NUM_REGS-1)
//   i_we      : commit a write this edge (caller guarantees i_widx != 0)
//   i_widx    : register index written
//   i_wdata   : write data
//   i_wstrb   : byte enables, bit b selects i_wdata[8b+7:8b]
//   i_ridx    : register index read (combinational)
//   o_rdata   : read data; index 0 always returns ID_VALUE
module axi4_lite_reg_bank #(
  parameter int                      DATA_WIDTH = 32,
  parameter int                      NUM_REGS   = 8,
  parameter int                      IDX_W      = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0]   ID_VALUE   = 32'hA11E_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [IDX_W-1:0]          i_widx,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic [IDX_W-1:0]          i_ridx,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  // Read-side view of every register; entry 0 is the constant ID word.
  logic [DATA_WIDTH-1:0] w_words [NUM_REGS];

  assign w_words[0] = ID_VALUE;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] r_word;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_word <= '0;
        end else if (i_we && (i_widx == IDX_W'(gi))) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_wstrb[b]) begin
              r_word[8*b +: 8] <= i_wdata[8*b +: 8];
            end
          end
        end
      end

      assign w_words[gi] = r_word;
    end
  endgenerate

  // Combinational read: a read decoded on the same edge as a write sees the old value.
  assign o_rdata = w_words[i_ridx];

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave terminating AW/W/B/AR/R in a small register file.
//   clk, rst                         : clock, synchronous active-high reset
//   awaddr/awvalid/awready           : write address channel
//   wdata/wstrb/wvalid/wready        : write data channel
//   bresp/bvalid/bready              : write response channel
//   araddr/arvalid/arready           : read address channel
//   rdata/rresp/rvalid/rready        : read data channel
// Reg 0 is a read-only ID, the rest are byte-strobed R/W. Misaligned,
// out-of-range and reg-0 writes answer SLVERR.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    NUM_REGS      = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 32'hA11E_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int LSB   = $clog2(DATA_WIDTH/8);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDRESS_WIDTH:0]   MAP_END  = (ADDRESS_WIDTH+1)'(NUM_REGS*(DATA_WIDTH/8));
  localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);

  function automatic logic addr_bad(input logic [ADDRESS_WIDTH-1:0] a);
    return ((a & LOW_MASK) != '0) || ({1'b0, a} >= MAP_END);
  endfunction

  logic                     r_aw_held, r_w_held;
  logic [ADDRESS_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH/8-1:0]  r_wstrb;
  logic                     r_awready, r_wready, r_arready;
  logic                     r_bvalid, r_rvalid;
  resp_t                    r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]    r_rdata;

  logic                     w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic                     w_aw_held_next, w_w_held_next, w_rvalid_next;
  logic                     w_wr_err, w_rd_err;
  logic [IDX_W-1:0]         w_widx, w_ridx;
  logic [DATA_WIDTH-1:0]    w_bank_rdata;

  assign w_aw_hs  = awvalid && r_awready;
  assign w_w_hs   = wvalid && r_wready;
  assign w_ar_hs  = arvalid && r_arready;
  // A held pair only commits once the previous response has left the B channel.
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;

  // Readies are low while their holding slot is full, so capture and commit never coincide.
  assign w_aw_held_next = w_commit ? 1'b0 : (r_aw_held || w_aw_hs);
  assign w_w_held_next  = w_commit ? 1'b0 : (r_w_held || w_w_hs);
  assign w_rvalid_next  = w_ar_hs || (r_rvalid && !rready);

  assign w_widx   = r_awaddr[LSB +: IDX_W];
  assign w_ridx   = araddr[LSB +: IDX_W];
  assign w_wr_err = addr_bad(r_awaddr) || (w_widx == '0);
  assign w_rd_err = addr_bad(araddr);

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit && !w_wr_err),
    .i_widx  (w_widx),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .i_ridx  (w_ridx),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_aw_held <= w_aw_held_next;
      r_w_held  <= w_w_held_next;
      r_awready <= !w_aw_held_next;
      r_wready  <= !w_w_held_next;
      r_arready <= !w_rvalid_next;

      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_err ? '0 : w_bank_rdata;
        r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign arready = r_arready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed plus randomized bench for axi4_lite_regfile_slave (32-bit data, 8 regs).
// Expected values come from an array model of the register map.
module tb_axi4_lite_regfile_slave;

  localparam logic [31:0] ID   = 32'hA11E_0001;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SLV  = 2'b10;
  localparam int          LIM  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [8];

  always #5 clk = ~clk;

  axi4_lite_regfile_slave #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_REGS(8), .ID_VALUE(32'hA11E_0001)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rules: word-aligned and inside the 32-byte map, reg 0 read-only.
  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32);
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [31:0] a);
    return (bad_addr(a) || a / 4 == 0) ? SLV : OKAY;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (exp_bresp(a) == OKAY)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    if (bad_addr(a)) begin d = 32'h0; r = SLV; end
    else if (a == 0) begin d = ID; r = OKAY; end
    else begin d = model[a / 4]; r = OKAY; end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, {31'b0, awready}, 32'h0);
    check({tag, "_wready"},  {31'b0, wready},  32'h0);
    check({tag, "_arready"}, {31'b0, arready}, 32'h0);
    check({tag, "_bvalid"},  {31'b0, bvalid},  32'h0);
    check({tag, "_bresp"},   {30'b0, bresp},   32'h0);
    check({tag, "_rvalid"},  {31'b0, rvalid},  32'h0);
    check({tag, "_rresp"},   {30'b0, rresp},   32'h0);
    check({tag, "_rdata"},   rdata,            32'h0);
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int  cyc;
    logic ah, wh;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    cyc = 0;
    while ((awvalid || wvalid) && cyc < LIM) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      step();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      cyc++;
    end
    if (cyc >= LIM) begin
      check("aw_w_timeout", {31'b0, awvalid || wvalid}, 32'h0);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic get_b(output logic [1:0] r);
    int cyc = 0;
    bready = 1'b1;
    while (!bvalid && cyc < LIM) begin step(); cyc++; end
    if (cyc >= LIM) check("b_timeout", {31'b0, bvalid}, 32'h1);
    r = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    send_aw_w(a, d, s);
    get_b(r);
    check("bresp", {30'b0, r}, {30'b0, exp_bresp(a)});
    $display("[TB] WR addr=%08h data=%08h strb=%h bresp=%0d", a, d, s, r);
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int cyc = 0;
    logic [1:0]  r;
    logic [31:0] ed;
    logic [1:0]  er;
    araddr = a; arvalid = 1'b1;
    while (!arready && cyc < LIM) begin step(); cyc++; end
    if (cyc >= LIM) check("ar_timeout", {31'b0, arready}, 32'h1);
    step();
    arvalid = 1'b0;
    rready = 1'b1;
    cyc = 0;
    while (!rvalid && cyc < LIM) begin step(); cyc++; end
    if (cyc >= LIM) check("r_timeout", {31'b0, rvalid}, 32'h1);
    d = rdata; r = rresp;
    step();
    rready = 1'b0;
    model_read(a, ed, er);
    check("rdata", d, ed);
    check("rresp", {30'b0, r}, {30'b0, er});
    $display("[TB] RD addr=%08h data=%08h rresp=%0d", a, d, r);
  endtask

  initial begin
    logic [31:0] d, d0, a;
    logic [1:0]  r;
    int cyc;

    // Reset state
    model_reset();
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();
    check("post_reset_awready", {31'b0, awready}, 32'h1);
    check("post_reset_arready", {31'b0, arready}, 32'h1);

    // AW and W in the same cycle, response one cycle later
    awaddr = 32'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_not_early", {31'b0, bvalid}, 32'h0);
    step();
    check("b_latency", {31'b0, bvalid}, 32'h1);
    check("b_okay", {30'b0, bresp}, {30'b0, OKAY});
    step();
    bready = 1'b0;
    check("b_cleared", {31'b0, bvalid}, 32'h0);
    model_write(32'h04, 32'hDEADBEEF, 4'hF);
    $display("[TB] WR addr=00000004 data=deadbeef same-cycle AW/W");
    axi_read(32'h04, d);

    // W three cycles before AW, then strobed merge
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    repeat (3) step();
    check("w_alone_no_b", {31'b0, bvalid}, 32'h0);
    awaddr = 32'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    get_b(r);
    check("w_first_bresp", {30'b0, r}, {30'b0, OKAY});
    model_write(32'h08, 32'h11223344, 4'hF);
    axi_write(32'h08, 32'hAABBCCDD, 4'b0101);
    axi_read(32'h08, d);
    check("strobe_merge", d, 32'h11BB33DD);

    // Error accesses and ID read
    axi_write(32'h00, 32'h12345678, 4'hF);
    axi_write(32'h40, 32'h12345678, 4'hF);
    axi_read(32'h20, d);
    axi_read(32'h06, d);
    axi_read(32'h00, d);
    check("id_value", d, 32'hA11E0001);

    // B back-pressure with a second write queued behind it
    send_aw_w(32'h14, 32'h12345678, 4'hF);
    cyc = 0;
    while (!bvalid && cyc < LIM) begin step(); cyc++; end
    check("bp_first_bvalid", {31'b0, bvalid}, 32'h1);
    send_aw_w(32'h00, 32'h0BADF00D, 4'hF);
    repeat (5) begin
      step();
      check("bp_bvalid_hold", {31'b0, bvalid}, 32'h1);
      check("bp_bresp_hold", {30'b0, bresp}, {30'b0, OKAY});
    end
    get_b(r);
    check("bp_first_resp", {30'b0, r}, {30'b0, OKAY});
    model_write(32'h14, 32'h12345678, 4'hF);
    check("bp_gap", {31'b0, bvalid}, 32'h0);
    step();
    check("bp_second_bvalid", {31'b0, bvalid}, 32'h1);
    get_b(r);
    check("bp_second_resp", {30'b0, r}, {30'b0, SLV});
    $display("[TB] WR back-pressure pair done");

    // R back-pressure
    araddr = 32'h04; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < LIM) begin step(); cyc++; end
    step();
    arvalid = 1'b0;
    check("rbp_rvalid", {31'b0, rvalid}, 32'h1);
    d0 = rdata;
    check("rbp_data", d0, model[1]);
    repeat (4) begin
      step();
      check("rbp_rvalid_hold", {31'b0, rvalid}, 32'h1);
      check("rbp_rdata_hold", rdata, d0);
      check("rbp_arready_low", {31'b0, arready}, 32'h0);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("rbp_rvalid_clear", {31'b0, rvalid}, 32'h0);
    check("rbp_arready_back", {31'b0, arready}, 32'h1);
    $display("[TB] RD back-pressure addr=00000004 data=%08h", d0);

    // AR on the same edge as a write commit to the same register
    awaddr = 32'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h0C; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check("raw_rvalid", {31'b0, rvalid}, 32'h1);
    check("raw_old_value", rdata, model[3]);
    check("raw_rresp", {30'b0, rresp}, {30'b0, OKAY});
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    model_write(32'h0C, 32'h5, 4'hF);
    $display("[TB] RD/WR same edge addr=0000000c");
    axi_read(32'h0C, d);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 9)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) axi_write(a, $urandom, 4'($urandom_range(0, 15)));
      else axi_read(a, d);
    end

    // Reset while AW is held and W is not
    axi_write(32'h10, 32'hCAFEF00D, 4'hF);
    awaddr = 32'h10; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    check_idle_outputs("midreset");
    rst = 1'b0;
    model_reset();
    step();
    wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    repeat (5) begin
      step();
      check("w_only_no_commit", {31'b0, bvalid}, 32'h0);
    end
    axi_read(32'h10, d);
    awaddr = 32'h14; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    get_b(r);
    check("post_reset_bresp", {30'b0, r}, {30'b0, OKAY});
    model_write(32'h14, 32'h99, 4'hF);
    axi_read(32'h14, d);
    axi_read(32'h10, d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
